// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage between decode and execute.
// Drives the register file read ports and aligns the registered read data with
// the accepted request. Writebacks are forwarded into the operands: same-cycle
// writebacks at accept time, and later writebacks while the result is stalled.
module regfile_operand_fetch #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_src2,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        HOLD
    } state_t;

    state_t state;
    state_t nextState;

    logic [ADDR_WIDTH-1:0] rs1Q;
    logic [ADDR_WIDTH-1:0] rs2Q;
    logic [TAG_WIDTH-1:0]  tagQ;
    logic                  byp1Q;
    logic                  byp2Q;
    logic [DATA_WIDTH-1:0] bypData1Q;
    logic [DATA_WIDTH-1:0] bypData2Q;
    logic [DATA_WIDTH-1:0] hold1Q;
    logic [DATA_WIDTH-1:0] hold2Q;

    logic                  accept;
    logic                  fire;
    logic                  wbHitNew1;
    logic                  wbHitNew2;
    logic                  wbHitHeld1;
    logic                  wbHitHeld2;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;

    // Handshakes and read addresses; the in_rs to rf_raddr path must stay
    // combinational so the RF answers in the cycle right after accept.
    always_comb begin
        out_valid = (state != IDLE);
        in_ready  = !rst && ((state == IDLE) || (out_valid && out_ready));
        accept    = in_valid && in_ready;
        fire      = out_valid && out_ready;
        rf_raddr1 = in_ready ? in_rs1 : '0;
        rf_raddr2 = in_ready ? in_rs2 : '0;
    end

    // Writeback matches against the incoming indices and the latched indices;
    // x0 never matches so writes to it are never forwarded.
    always_comb begin
        wbHitNew1  = wb_wen && (wb_waddr == in_rs1) && (in_rs1 != '0);
        wbHitNew2  = wb_wen && (wb_waddr == in_rs2) && (in_rs2 != '0);
        wbHitHeld1 = wb_wen && (wb_waddr == rs1Q) && (rs1Q != '0);
        wbHitHeld2 = wb_wen && (wb_waddr == rs2Q) && (rs2Q != '0);
    end

    // Operand selection: x0 reads zero, then the accept-time bypass, then the
    // freshly returned RF data; in HOLD the local copies are shown.
    always_comb begin
        src1    = '0;
        src2    = '0;
        out_tag = '0;
        case (state)
            DATA: begin
                src1    = (rs1Q == '0) ? '0 : (byp1Q ? bypData1Q : rf_rdata1);
                src2    = (rs2Q == '0) ? '0 : (byp2Q ? bypData2Q : rf_rdata2);
                out_tag = tagQ;
            end
            HOLD: begin
                src1    = hold1Q;
                src2    = hold2Q;
                out_tag = tagQ;
            end
            default: begin
                src1    = '0;
                src2    = '0;
                out_tag = '0;
            end
        endcase
        out_src1 = src1;
        out_src2 = src2;
    end

    // Next-state logic: a new request always lands in DATA; an unaccepted
    // result in DATA moves to HOLD because the RF data is only valid once.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = DATA;
                end
            end
            DATA, HOLD: begin
                if (fire) begin
                    nextState = accept ? DATA : IDLE;
                end else begin
                    nextState = HOLD;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Request capture: indices, sideband and any writeback landing on the
    // accept edge, which the registered RF read cannot see.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1Q      <= '0;
            rs2Q      <= '0;
            tagQ      <= '0;
            byp1Q     <= 1'b0;
            byp2Q     <= 1'b0;
            bypData1Q <= '0;
            bypData2Q <= '0;
        end else if (accept) begin
            rs1Q      <= in_rs1;
            rs2Q      <= in_rs2;
            tagQ      <= in_tag;
            byp1Q     <= wbHitNew1;
            byp2Q     <= wbHitNew2;
            bypData1Q <= wbHitNew1 ? wb_wdata : '0;
            bypData2Q <= wbHitNew2 ? wb_wdata : '0;
        end
    end

    // Hold registers: snapshot the shown operands when execute stalls, and
    // keep folding in writebacks to the same sources while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold1Q <= '0;
            hold2Q <= '0;
        end else if ((state == DATA) && !fire) begin
            hold1Q <= wbHitHeld1 ? wb_wdata : src1;
            hold2Q <= wbHitHeld2 ? wb_wdata : src2;
        end else if ((state == HOLD) && !fire) begin
            if (wbHitHeld1) begin
                hold1Q <= wb_wdata;
            end
            if (wbHitHeld2) begin
                hold2Q <= wb_wdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Testbench for regfile_operand_fetch with a registered-read register file
// model, directed stimulus and a queue-based scoreboard monitor.
module tb_regfile_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_tag;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [31:0] out_tag;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] lastOutValid;
    logic [31:0] lastWait;
    logic [31:0] rfMem [32];

    regfile_operand_fetch #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .TAG_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .in_tag(in_tag),
        .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen),
        .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src1(out_src1),
        .out_src2(out_src2),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: registered reads, no write-to-read forwarding.
    always @(posedge clk) begin
        rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : rfMem[rf_raddr1];
        rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : rfMem[rf_raddr2];
        if (wb_wen && (wb_waddr != 5'd0)) begin
            rfMem[wb_waddr] <= wb_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every output fire pops the oldest expectation;
    // idle outputs must read zero.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedFireTag", out_tag, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("fireSrc1", out_src1, e.src1);
                checkOutput("fireSrc2", out_src2, e.src2);
                checkOutput("fireTag", out_tag, e.tag);
            end
        end else if (!rst && !out_valid) begin
            checkOutput("idleZero", out_src1 | out_src2 | out_tag, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        wb_wen   = 1'b1;
        wb_waddr = addr;
        wb_wdata = data;
        nextCycle();
        wb_wen   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] tag,
                                 input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        int   waitCnt;
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_tag   = tag;
        e.src1   = e1;
        e.src2   = e2;
        e.tag    = tag;
        sb.push_back(e);
        waitCnt  = 0;
        @(negedge clk);
        lastOutValid = {31'd0, out_valid};
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        lastWait = waitCnt;
        checkOutput("acceptReady", {31'd0, in_ready}, 32'd1);
        nextCycle();
    endtask

    logic [4:0]  b2bRs1 [4] = '{5'd1, 5'd4, 5'd9, 5'd10};
    logic [4:0]  b2bRs2 [4] = '{5'd2, 5'd8, 5'd9, 5'd1};
    logic [31:0] b2bE1  [4] = '{32'hA1, 32'hA4, 32'hBEEF, 32'hAA};
    logic [31:0] b2bE2  [4] = '{32'hA2, 32'hA8, 32'hBEEF, 32'hA1};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_rs1    = 5'd5;
        in_rs2    = 5'd6;
        in_tag    = 32'h0;
        wb_wen    = 1'b0;
        wb_waddr  = 5'd0;
        wb_wdata  = 32'd0;
        out_ready = 1'b1;

        // Reset state with a request pending at the inputs.
        nextCycle();
        @(negedge clk);
        checkOutput("resetOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("resetInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("resetRaddr1", {27'd0, rf_raddr1}, 32'd0);
        nextCycle();
        rst      = 1'b0;
        in_valid = 1'b0;

        // Preload the register file through the writeback port.
        writeReg(5'd5, 32'h11);
        writeReg(5'd6, 32'h22);
        writeReg(5'd7, 32'h1);
        writeReg(5'd3, 32'h10);
        writeReg(5'd1, 32'hA1);
        writeReg(5'd2, 32'hA2);
        writeReg(5'd4, 32'hA4);
        writeReg(5'd8, 32'hA8);
        writeReg(5'd9, 32'hA9);
        writeReg(5'd10, 32'hAA);
        writeReg(5'd12, 32'hC);
        writeReg(5'd13, 32'hD);

        // Basic read with one-cycle latency.
        applyStimulus(5'd5, 5'd6, 32'h8000_0000, 32'h11, 32'h22);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("basicValid", {31'd0, out_valid}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("basicBubble", {31'd0, out_valid}, 32'd0);
        nextCycle();

        // Same-cycle bypass, and a write to x0 is not forwarded.
        wb_wen   = 1'b1;
        wb_waddr = 5'd7;
        wb_wdata = 32'hDEAD;
        applyStimulus(5'd7, 5'd0, 32'h77, 32'hDEAD, 32'd0);
        wb_waddr = 5'd0;
        wb_wdata = 32'h55;
        applyStimulus(5'd5, 5'd0, 32'h78, 32'h11, 32'd0);
        wb_wen   = 1'b0;
        in_valid = 1'b0;
        nextCycle();
        nextCycle();

        // Stall with a writeback during the second stall cycle.
        out_ready = 1'b0;
        applyStimulus(5'd3, 5'd0, 32'h33, 32'h99, 32'd0);
        begin
            exp_t e2;
            in_rs1  = 5'd5;
            in_rs2  = 5'd6;
            in_tag  = 32'h44;
            e2.src1 = 32'h11;
            e2.src2 = 32'h22;
            e2.tag  = 32'h44;
            sb.push_back(e2);
        end
        @(negedge clk);
        checkOutput("stall1Src1", out_src1, 32'h10);
        checkOutput("stall1InReady", {31'd0, in_ready}, 32'd0);
        checkOutput("stall1Valid", {31'd0, out_valid}, 32'd1);
        nextCycle();
        wb_wen   = 1'b1;
        wb_waddr = 5'd3;
        wb_wdata = 32'h99;
        @(negedge clk);
        checkOutput("stall2Src1", out_src1, 32'h10);
        checkOutput("stall2InReady", {31'd0, in_ready}, 32'd0);
        nextCycle();
        wb_wen = 1'b0;
        @(negedge clk);
        checkOutput("stall3Src1", out_src1, 32'h99);
        checkOutput("stall3InReady", {31'd0, in_ready}, 32'd0);
        nextCycle();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("stallReleaseReady", {31'd0, in_ready}, 32'd1);
        nextCycle();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stallNextValid", {31'd0, out_valid}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("stallDrained", {31'd0, out_valid}, 32'd0);
        nextCycle();

        // Back-to-back requests, including rs1==rs2 with a bypass.
        for (int i = 0; i < 4; i++) begin
            wb_wen   = (i == 2);
            wb_waddr = 5'd9;
            wb_wdata = 32'hBEEF;
            applyStimulus(b2bRs1[i], b2bRs2[i], 32'h100 + 32'(i), b2bE1[i], b2bE2[i]);
            if (i > 0) begin
                checkOutput("b2bNoBubble", lastOutValid, 32'd1);
            end
        end
        wb_wen   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2bLastValid", {31'd0, out_valid}, 32'd1);
        nextCycle();
        nextCycle();

        // Stall in DATA with a same-cycle write to rs2.
        out_ready = 1'b0;
        applyStimulus(5'd12, 5'd13, 32'h55, 32'hC, 32'h777);
        in_valid = 1'b0;
        wb_wen   = 1'b1;
        wb_waddr = 5'd13;
        wb_wdata = 32'h777;
        @(negedge clk);
        checkOutput("dataStallSrc2", out_src2, 32'hD);
        nextCycle();
        wb_wen    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("holdCapturedSrc2", out_src2, 32'h777);
        nextCycle();
        nextCycle();

        // Reset while holding a result; the request is dropped.
        out_ready = 1'b0;
        applyStimulus(5'd5, 5'd6, 32'h99, 32'h11, 32'h22);
        in_valid = 1'b0;
        nextCycle();
        rst      = 1'b1;
        sb.delete();
        in_valid = 1'b1;
        in_rs1   = 5'd5;
        @(negedge clk);
        checkOutput("rstHoldInReady", {31'd0, in_ready}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("rstRaddr1", {27'd0, rf_raddr1}, 32'd0);
        nextCycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(5'd5, 5'd6, 32'hAB, 32'h11, 32'h22);
        checkOutput("acceptAfterReset", lastWait, 32'd0);
        in_valid = 1'b0;
        nextCycle();
        nextCycle();
        nextCycle();

        checkOutput("scoreboardEmpty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Read-side client of the NPC register file, which has registered read ports (address in cycle N, data valid in cycle N+1, and no write-to-read forwarding).
- Accepts source-register indices from decode over a valid/ready handshake, drives the two RF read addresses, and aligns the returned data with the request.
- Forwards same-cycle writebacks into the operands and holds them stable under downstream backpressure.
- Sits between decode and execute.

Parameters:
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers, x0 hardwired zero)
DATA_WIDTH, 32, register data width
TAG_WIDTH, 32, sideband carried with each request (e.g. pc/inst), passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  decode request valid
in_ready  out  1  block can accept a request this cycle
in_rs1  in  ADDR_WIDTH  source index 1
in_rs2  in  ADDR_WIDTH  source index 2
in_tag  in  TAG_WIDTH  sideband
rf_raddr1  out  ADDR_WIDTH  to RF raddr1
rf_raddr2  out  ADDR_WIDTH  to RF raddr2
rf_rdata1  in  DATA_WIDTH  from RF rdata1 (registered, 1-cycle latency)
rf_rdata2  in  DATA_WIDTH  from RF rdata2
wb_wen  in  1  writeback enable (same signal that drives RF wen)
wb_waddr  in  ADDR_WIDTH  writeback index
wb_wdata  in  DATA_WIDTH  writeback data
out_valid  out  1  operands valid
out_ready  in  1  execute accepts
out_src1  out  DATA_WIDTH  operand 1
out_src2  out  DATA_WIDTH  operand 2
out_tag  out  TAG_WIDTH  sideband

Behaviour:
- States:
  - IDLE: no request.
  - DATA: RF data arriving this cycle.
  - HOLD: operands latched locally.
- Handshakes:
  - in_ready = !rst && (state==IDLE || (out_valid && out_ready)).
  - Accept when in_valid && in_ready.
  - out fire = out_valid && out_ready.
- Read addresses:
  - rf_raddr1/2 = in_rs1/2 when in_ready; otherwise 0.
  - The combinational path from in_rs to rf_raddr is required for 1-cycle latency.
- Accept edge: latch rs1, rs2 and tag. For each source i, set byp_i=1 and byp_data_i=wb_wdata if wb_wen && wb_waddr==rs_i && rs_i!=0; else byp_i=0. Go to DATA.
- DATA:
  - out_valid=1.
  - out_src_i = 0 if rs_i==0, else byp_data_i if byp_i, else rf_rdata_i.
  - out_tag = latched tag.
  - On fire: go to DATA if a new request is accepted the same cycle, else IDLE.
  - Without fire: latch the current out_src values into hold registers, applying same-cycle writeback forwarding (a wb_wen to rs_i!=0 overrides). Go to HOLD.
- HOLD:
  - out_valid=1; outputs come from hold registers.
  - At every edge while held, a wb_wen with wb_waddr==rs_i, rs_i!=0, updates hold_i (last write wins).
  - On fire: go to DATA if a new request is accepted, else IDLE.
- Latency: one cycle from accept to out_valid. Throughput is one request per cycle when out_ready stays high.
- Operand semantics: the operand equals the register value including every writeback presented up to and including the cycle before the operand is first shown. While stalled, later writebacks are also included.
- Writes to x0 are never forwarded.
- rs1==rs2: both sources are forwarded identically.
- When out_valid=0: out_src1/2=0 and out_tag=0.
- Reset (including mid-request, in any state): state=IDLE, out_valid=0, in_ready=0 during rst, rf_raddr=0, hold/byp registers cleared. The pending request is dropped. First accept is possible in the cycle after rst deasserts.

Test Plan:
- Basic read: preload RF x5=0x11, x6=0x22; request rs1=5, rs2=6, tag=0x80000000, out_ready=1 -> next cycle out_valid=1, src1=0x11, src2=0x22, tag=0x80000000; following cycle out_valid=0.
- Same-cycle bypass: accept rs1=7 while wb writes x7=0xDEAD; RF holds the old value 0x1 -> out_src1=0xDEAD. Write x0=0x55 with rs2=0 -> out_src2=0.
- Stall and update: request rs1=3 (x3=0x10), out_ready=0 for 3 cycles, and a write x3=0x99 during the second stall cycle -> out_src1 shows 0x10, then 0x99 from the next cycle. With in_valid held, in_ready=0 throughout; on out_ready=1 a single fire occurs.
- Back-to-back: 4 consecutive requests with out_ready=1 -> 4 consecutive out_valid cycles, correct operands and tags in order, no bubbles.
- Stall in DATA with a same-cycle write to rs2 -> the hold register captures the wb_wdata value, not rf_rdata.
- Reset mid-request: assert rst in HOLD -> next cycle out_valid=0, in_ready=0 while rst is high; after release, a new request completes normally.
